// File: rtl/medicine_pkg.sv
// Shared types and sizing helpers for the medicine reminder scheduler.
// Holds the per-channel FSM encoding and the wait-counter width rule.
package medicine_pkg;

    typedef enum logic [1:0] {
        ST_COUNT   = 2'd0,
        ST_REMIND  = 2'd1,
        ST_OVERDUE = 2'd2
    } state_t;

    // Wait counter must hold 0..ACK_TIMEOUT-1 with headroom.
    function automatic int wait_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

    localparam int ACK_TIMEOUT_DEF = 8;
    localparam int WAIT_W          = $clog2(ACK_TIMEOUT_DEF) + 1;

endpackage

// File: rtl/medicine_channel.sv
// One reminder channel: free-running period counter, ack wait counter, FSM.
// Ports: clk/reset/enable, period, ack -> reminder, missed, miss_pulse.
module medicine_channel
    import medicine_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic             ack,
    output logic             reminder,
    output logic             missed,
    output logic             miss_pulse
);

    localparam int WW = wait_width(ACK_TIMEOUT);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [WW-1:0]    wt;
    logic             active;
    logic             expire;
    logic             timeout;

    assign active  = (period != '0);
    // >= so a period shrunk below the current count still expires.
    assign expire  = active && (cnt >= period - CNT_W'(1));
    assign timeout = (wt == WW'(ACK_TIMEOUT - 1));

    // High for the edge on which this channel registers a missed dose.
    assign miss_pulse = enable && active && (st == ST_REMIND) && !ack
                        && (timeout || expire);

    assign reminder = (st == ST_REMIND);
    assign missed   = (st == ST_OVERDUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= ST_COUNT;
            cnt <= '0;
            wt  <= '0;
        end else if (enable) begin
            if (!active) begin
                st  <= ST_COUNT;
                cnt <= '0;
                wt  <= '0;
            end else begin
                cnt <= expire ? '0 : cnt + CNT_W'(1);
                unique case (st)
                    ST_COUNT: begin
                        if (expire) begin
                            st <= ST_REMIND;
                            wt <= '0;
                        end
                    end
                    ST_REMIND: begin
                        wt <= wt + WW'(1);
                        if (ack) begin
                            st <= ST_COUNT;
                        end else if (timeout) begin
                            st <= ST_OVERDUE;
                        end else if (expire) begin
                            wt <= '0;
                        end
                    end
                    ST_OVERDUE: begin
                        if (ack) begin
                            st <= ST_COUNT;
                        end else if (expire) begin
                            st <= ST_REMIND;
                            wt <= '0;
                        end
                    end
                    default: st <= ST_COUNT;
                endcase
            end
        end
    end

endmodule

// File: rtl/medicine_scheduler.sv
// Multi-channel medicine reminder with a shared saturating missed-dose count.
// Ports: clk, reset, enable, period_cfg, ack -> reminder/missed, any_alert, miss_count.
module medicine_scheduler
    import medicine_pkg::*;
#(
    parameter int NUM_DOSES   = 4,
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int MISS_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_DOSES*CNT_W-1:0] period_cfg,
    input  logic [NUM_DOSES-1:0]       ack,
    output logic [NUM_DOSES-1:0]       medicine_reminder,
    output logic [NUM_DOSES-1:0]       medicine_missed,
    output logic                       any_alert,
    output logic [MISS_W-1:0]          miss_count
);

    localparam int PC_W  = $clog2(NUM_DOSES + 1);
    localparam int SUM_W = MISS_W + PC_W;
    localparam logic [SUM_W-1:0] MAX = SUM_W'({MISS_W{1'b1}});

    logic [NUM_DOSES-1:0] pulse;
    logic [PC_W-1:0]      pc;
    logic [SUM_W-1:0]     sum;
    logic [MISS_W-1:0]    nxt;

    for (genvar i = 0; i < NUM_DOSES; i++) begin : g_ch
        medicine_channel #(
            .CNT_W       (CNT_W),
            .ACK_TIMEOUT (ACK_TIMEOUT)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .period     (period_cfg[i*CNT_W +: CNT_W]),
            .ack        (ack[i]),
            .reminder   (medicine_reminder[i]),
            .missed     (medicine_missed[i]),
            .miss_pulse (pulse[i])
        );
    end

    // Several channels can miss on the same edge; add them all at once.
    always_comb begin
        pc = '0;
        for (int i = 0; i < NUM_DOSES; i++) begin
            pc = pc + PC_W'(pulse[i]);
        end
        sum = SUM_W'(miss_count) + SUM_W'(pc);
        nxt = (sum > MAX) ? {MISS_W{1'b1}} : sum[MISS_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_count <= '0;
        end else if (enable) begin
            miss_count <= nxt;
        end
    end

    assign any_alert = |{medicine_reminder, medicine_missed};

endmodule
